// File: rtl/pipe_full_add_pkg.sv
// ---------------------------------------------------------------------------
// pipe_full_add_pkg : mode encodings, configuration check, 1-bit full-add cell
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_full_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_full_add_seg.sv
// ---------------------------------------------------------------------------
// add_seg : combinational SEG-bit ripple adder built from full-add cells
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module add_seg
  import pipe_full_add_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_cell
    assign {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
  end

  assign cout  = carry[SEG];
  assign c_msb = carry[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipe_full_add.sv
// ---------------------------------------------------------------------------
// pipe_full_add : pipelined WIDTH-bit adder/subtractor, one SEG-bit segment
//                 resolved per stage, valid/ready on both sides. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_full_add
  import pipe_full_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_full_add: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Per-stage registers; lower segments of sum_q hold finished results,
  // a_q/b_q carry the not-yet-consumed upper operand segments.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             ovf_q;

  logic             src_v   [STAGES];
  logic             src_c   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_cout[STAGES];
  logic             seg_cmsb[STAGES];

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Subtract folds into inverted B and carry-in here; later stages only add.
  assign b_eff   = (in_sub == MODE_SUB) ? ~in_b : in_b;
  assign cin_eff = in_sub ^ in_cin;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign src_v[s]   = in_valid;
      assign src_c[s]   = cin_eff;
      assign src_a[s]   = in_a;
      assign src_b[s]   = b_eff;
      assign src_sum[s] = '0;
    end else begin : g_body
      assign src_v[s]   = v_q[s-1];
      assign src_c[s]   = c_q[s-1];
      assign src_a[s]   = a_q[s-1];
      assign src_b[s]   = b_q[s-1];
      assign src_sum[s] = sum_q[s-1];
    end

    add_seg #(
      .SEG(SEG)
    ) u_seg (
      .a    (src_a[s][s*SEG +: SEG]),
      .b    (src_b[s][s*SEG +: SEG]),
      .cin  (src_c[s]),
      .sum  (seg_sum[s]),
      .cout (seg_cout[s]),
      .c_msb(seg_cmsb[s])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      nxt_sum[s]               = src_sum[s];
      nxt_sum[s][s*SEG +: SEG] = seg_sum[s];
    end
  end

  // Valid bits always advance with en; data only loads behind a valid token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= 1'b0;
        c_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= src_v[s];
        if (src_v[s]) begin
          c_q[s]   <= seg_cout[s];
          a_q[s]   <= src_a[s];
          b_q[s]   <= src_b[s];
          sum_q[s] <= nxt_sum[s];
        end
      end
      if (src_v[LAST]) begin
        ovf_q <= seg_cout[LAST] ^ seg_cmsb[LAST];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_full_add.sv
// ---------------------------------------------------------------------------
// tb_pipe_full_add : directed table, stall/reset sequences, and randomised
//                    scoreboard across three configurations. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_full_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b;

  logic        ir0, ov0, co0, of0;
  logic [31:0] sum0;
  logic        ir1, ov1, co1, of1;
  logic [7:0]  sum1;
  logic        ir2, ov2, co2, of2;
  logic [15:0] sum2;

  pipe_full_add #(.WIDTH(32), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_cout(co0), .out_ovf(of0)
  );

  pipe_full_add #(.WIDTH(8), .STAGES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_cout(co1), .out_ovf(of1)
  );

  pipe_full_add #(.WIDTH(16), .STAGES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_cout(co2), .out_ovf(of2)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    longint one = 1;
    longint full = one << w;
    longint half = one << (w - 1);
    longint ua, ub, sa, sb, r;
    res_t   m;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (sub) begin
      r      = sa - sb - longint'(cin);
      m.cout = (ua >= ub + longint'(cin));
    end else begin
      r      = sa + sb + longint'(cin);
      m.cout = ((ua + ub + longint'(cin)) >= full);
    end
    m.ovf = (r < -half) || (r > half - 1);
    m.sum = 32'(r & (full - 1));
    return m;
  endfunction

  // Scoreboard for all three instances, running for the whole test.
  logic        m_ir[3], m_ov[3], m_co[3], m_of[3];
  logic [31:0] m_sum[3];
  int          widths[3] = '{32, 8, 16};
  res_t        q[3][$];
  int          xfer[3] = '{0, 0, 0};

  assign m_ir[0] = ir0;  assign m_ov[0] = ov0;  assign m_co[0] = co0;  assign m_of[0] = of0;
  assign m_ir[1] = ir1;  assign m_ov[1] = ov1;  assign m_co[1] = co1;  assign m_of[1] = of1;
  assign m_ir[2] = ir2;  assign m_ov[2] = ov2;  assign m_co[2] = co2;  assign m_of[2] = of2;
  assign m_sum[0] = sum0;
  assign m_sum[1] = {24'd0, sum1};
  assign m_sum[2] = {16'd0, sum2};

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb%0d_unexpected: got result %0h expected none", k, m_sum[k]);
          end else begin
            e = q[k].pop_front();
            check($sformatf("sb%0d_sum", k),  64'(m_sum[k]), 64'(e.sum));
            check($sformatf("sb%0d_cout", k), 64'(m_co[k]),  64'(e.cout));
            check($sformatf("sb%0d_ovf", k),  64'(m_of[k]),  64'(e.ovf));
          end
        end
        if (in_valid && m_ir[k]) begin
          q[k].push_back(model(widths[k], in_a, in_b, in_cin, in_sub));
          xfer[k]++;
        end
      end
    end
  end

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t tbl[9];
  vec_t sv[8];
  res_t ex[8];
  res_t hold;

  initial begin
    int lat, idx, got, cyc, acc;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_out_sum",   64'(sum0), 64'd0);
    check("rst_out_cout",  64'(co0), 64'd0);
    check("rst_out_ovf",   64'(of0), 64'd0);
    check("rst_in_ready",  64'(ir0), 64'd1);
    check("rst_valid_8x8", 64'(ov1), 64'd0);
    rst_n = 1'b1;

    // Directed table: one operation at a time, latency STAGES.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b;
      in_cin = tbl[i].cin; in_sub = tbl[i].sub;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!ov0 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("tbl%0d_sum", i),  64'(sum0), 64'(tbl[i].sum));
      check($sformatf("tbl%0d_cout", i), 64'(co0),  64'(tbl[i].cout));
      check($sformatf("tbl%0d_ovf", i),  64'(of0),  64'(tbl[i].ovf));
    end
    repeat (6) @(posedge clk);

    // Back-to-back stream with a 3-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      sv[i].a   = 32'h1357_9BDF * (i + 1) + 32'(i);
      sv[i].b   = 32'hF0E1_D2C3 ^ (32'h0101_0101 << i);
      sv[i].cin = i[1];
      sv[i].sub = i[0];
      ex[i] = model(32, sv[i].a, sv[i].b, sv[i].cin, sv[i].sub);
    end
    idx = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 5 && cyc < 8);
      if (idx < 8) begin
        in_valid = 1'b1; in_a = sv[idx].a; in_b = sv[idx].b;
        in_cin = sv[idx].cin; in_sub = sv[idx].sub;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("stall_in_ready", 64'(ir0), 64'd0);
        check("stall_out_valid", 64'(ov0), 64'd1);
        if (cyc == 5) begin
          hold.sum = sum0; hold.cout = co0; hold.ovf = of0;
        end else begin
          check("stall_sum_stable",  64'(sum0), 64'(hold.sum));
          check("stall_cout_stable", 64'(co0),  64'(hold.cout));
          check("stall_ovf_stable",  64'(of0),  64'(hold.ovf));
        end
      end
      if (ov0 && out_ready) begin
        check($sformatf("stream%0d_sum", got), 64'(sum0), 64'(ex[got].sum));
        check($sformatf("stream%0d_cout", got), 64'(co0), 64'(ex[got].cout));
        got++;
      end
      if (in_valid && ir0) idx++;
      cyc++;
    end
    check("stream_count", 64'(got), 64'd8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("stream_no_duplicate", 64'(ov0), 64'd0);
    end

    // Fill the pipeline under back-pressure, then reset mid-flight.
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 20) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 32'hA5A5_0000 + 32'(acc); in_b = 32'd1;
      in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      if (in_valid && ir0) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("prefill_out_valid", 64'(ov0), 64'd1);
    check("prefill_sum", 64'(sum0), 64'hA5A5_0001);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov0), 64'd0);
    check("midrst_out_sum",   64'(sum0), 64'd0);
    check("midrst_out_cout",  64'(co0), 64'd0);
    check("midrst_in_ready",  64'(ir0), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_quiet", 64'(ov0 | ov1 | ov2), 64'd0);
    end

    // Randomised traffic on all three configurations.
    for (int k = 0; k < 3; k++) xfer[k] = 0;
    cyc = 0;
    while ((xfer[0] < 10000 || xfer[1] < 10000 || xfer[2] < 10000) && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = rnd_op(); in_b = rnd_op();
      in_cin = 1'($urandom); in_sub = 1'($urandom);
      cyc++;
    end
    check("random_budget", 64'(cyc < 40000), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain%0d_empty", k), 64'(q[k].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_full_add.md
# pipe_full_add

Parametrised, pipelined ripple-carry adder/subtractor: a WIDTH-bit operation is split into STAGES equal segments, one segment resolved per clock, with a valid/ready handshake on both sides. It is the multi-bit, registered successor to the team's 1-bit combinational full adder. It sits in datapaths that need wide add/sub at full clock rate without a long carry chain in one cycle. It also fixes the carry-out naming so the declared port is the driven port.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; segment width SEG = WIDTH/STAGES; legal range 1..WIDTH.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (add) / borrow-in (sub).
- in_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  raw carry out of MSB.
- out_ovf  output  1  two's-complement overflow.

## Operation
- Add: out_sum = in_a + in_b + in_cin.
- Sub: out_sum = in_a + ~in_b + (1 - in_cin), i.e. A − B − borrow; carry into bit 0 = in_sub ^ in_cin.
- out_cout: carry out of bit WIDTH-1, unmodified. In sub mode, 1 = no borrow.
- out_ovf = carry into MSB XOR carry out of MSB.
- Stage i (0..STAGES-1) adds segment i using the carry registered by stage i-1.
- Higher operand segments travel in skew registers until their stage.
- Finished lower sum segments travel in deskew registers, so all WIDTH bits emerge together.
- Each stage carries a valid bit. Mode is folded into B and carry at stage 0; later stages are mode-agnostic.
- Pipeline enable: en = out_ready || !out_valid. All stage registers advance only when en = 1. in_ready = en.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stall: outputs and all in-flight data hold unchanged. No transfer is dropped or duplicated. Order is preserved.
- in_valid = 0 when en = 1 inserts a bubble; bubbles advance normally.
- Operands sampled only on transfer in. Values while in_ready = 0 are ignored.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0, all skew/deskew/carry registers 0.
- in_ready is combinational from out_ready and out_valid. During reset in_ready = 1 (out_valid = 0).
- Latency: a transfer in the cycle ending at edge k produces out_valid = 1 in the cycle after edge k+STAGES-1. That is STAGES cycles with no stall; each stall cycle adds one.
- Throughput: one result per cycle while out_ready = 1.
- STAGES = 1: single registered adder, latency 1.
- Simultaneous transfer in and transfer out in one cycle is normal streaming; occupancy stays unchanged.
- Reset mid-operation: all in-flight operations are discarded. After rst_n rises, nothing emerges until new inputs are accepted.
- Critical path: one SEG-bit ripple plus operand inversion at stage 0.

## Structure
- Shared package/header: mode encodings MODE_ADD = 0 and MODE_SUB = 1. Also parameter legality check: WIDTH % STAGES == 0, else elaboration error.
- Sub-module add_seg: combinational SEG-bit adder with inputs a, b, cin and outputs sum, cout, c_msb (carry into its top bit), built from 1-bit full-add cells. Instantiated STAGES times via generate.
- Top level holds valid chain, skew/deskew arrays, carry registers and handshake logic.

## Test plan
- WIDTH=32, STAGES=4, add, A=0xFFFFFFFF, B=1, cin=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
- Add A=0x7FFFFFFF, B=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Add A=0x80000000, B=0x80000000 -> sum=0, cout=1, ovf=1.
- Sub A=5, B=7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Sub A=7, B=5, cin=1 -> sum=1, cout=1.
- Stream 8 back-to-back vectors; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and out_* stable during the stall, all 8 results exact and in order, no duplicates.
- Three operations in flight, pulse rst_n low for 1 cycle -> out_valid=0 immediately, outputs zero, no stale result ever appears.
- Randomised add/sub, random valid/ready, vs. golden model at WIDTH=32/STAGES=4, WIDTH=8/STAGES=8, WIDTH=16/STAGES=1 -> zero mismatches over 10k transfers.
